// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: the ROB-to-BTB update bus and the update-queue entry format.
package rv32i_types;

    localparam int unsigned BTB_UQ_COMMIT_WIDTH_MAX = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pred_branch_address;
        logic        jal_inst;
        logic        branch_inst;
        logic        branch_resol;
        logic        ready;
        logic        valid;
    } rob_to_btb_bus;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pred_branch_address;
        logic        jal_inst;
        logic        branch_inst;
        logic        branch_resol;
    } btb_uq_entry_t;

    function automatic logic [31:0] uq_sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

endpackage

// File: rtl/btb_commit_update_queue_compactor.sv
// btb_uq_compactor: packs qualifying commit slots into consecutive queue offsets and
// drops (highest slot first) whatever does not fit into the available space.
module btb_uq_compactor #(
    parameter int unsigned COMMIT_WIDTH = 2,
    parameter int unsigned CNT_W        = 4
) (
    input  logic [COMMIT_WIDTH-1:0]                 i_qual,
    input  logic [CNT_W-1:0]                        i_space,
    output logic [COMMIT_WIDTH-1:0][CNT_W-2:0]      o_offset,
    output logic [COMMIT_WIDTH-1:0]                 o_accept,
    output logic [CNT_W-1:0]                        o_n_enq,
    output logic [CNT_W-1:0]                        o_n_drop
);

    logic [CNT_W-1:0] w_cnt;

    always_comb begin
        w_cnt    = '0;
        o_n_drop = '0;
        o_offset = '0;
        o_accept = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            o_offset[i] = w_cnt[CNT_W-2:0];
            if (i_qual[i]) begin
                // Lower slots claim space first, so overflow always sheds the youngest slot.
                if (w_cnt < i_space) begin
                    o_accept[i] = 1'b1;
                    w_cnt       = w_cnt + 1'b1;
                end else begin
                    o_n_drop = o_n_drop + 1'b1;
                end
            end
        end
        o_n_enq = w_cnt;
    end

endmodule

// File: rtl/btb_commit_update_queue.sv
// In-order FIFO of committed jal/branch updates feeding the BTB at one entry per cycle.
// Define BTB_UQ_STATS_EN to add saturating statistics counters.
module btb_commit_update_queue
    import rv32i_types::*;
#(
    parameter int unsigned UQ_DEPTH      = 8,
    parameter int unsigned UQ_DEPTH_BITS = 3,
    parameter int unsigned COMMIT_WIDTH  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [COMMIT_WIDTH-1:0]      commit_valid,
    input  logic [COMMIT_WIDTH-1:0][31:0] commit_pc,
    input  logic [COMMIT_WIDTH-1:0][31:0] commit_target,
    input  logic [COMMIT_WIDTH-1:0]      commit_is_jal,
    input  logic [COMMIT_WIDTH-1:0]      commit_is_branch,
    input  logic [COMMIT_WIDTH-1:0]      commit_taken,
    output logic                         commit_stall,
    output rob_to_btb_bus                btb_upd,
    output logic [UQ_DEPTH_BITS:0]       uq_count,
    output logic                         uq_overflow
`ifdef BTB_UQ_STATS_EN
    ,
    output logic [31:0]                  stat_enq,
    output logic [31:0]                  stat_taken,
    output logic [31:0]                  stat_jal,
    output logic [31:0]                  stat_drop,
    output logic [31:0]                  stat_stall_cycles
`endif
);

    localparam int unsigned CNT_W = UQ_DEPTH_BITS + 1;
    localparam int unsigned IDX_W = UQ_DEPTH_BITS;

    logic [CNT_W-1:0]                  r_head;
    logic [CNT_W-1:0]                  r_tail;
    logic                              r_overflow;
    btb_uq_entry_t                     r_mem [UQ_DEPTH];

    logic [CNT_W-1:0]                  w_count;
    logic [CNT_W-1:0]                  w_space;
    logic [CNT_W-1:0]                  w_n_enq;
    logic [CNT_W-1:0]                  w_n_drop;
    logic                              w_deq;
    logic [COMMIT_WIDTH-1:0]           w_qual;
    logic [COMMIT_WIDTH-1:0]           w_accept;
    logic [COMMIT_WIDTH-1:0][IDX_W-1:0] w_offset;
    btb_uq_entry_t [COMMIT_WIDTH-1:0]  w_entry;
    btb_uq_entry_t                     w_head_entry;

    assign w_count      = r_tail - r_head;
    assign w_deq        = (w_count != '0);
    // Space counts the slot freed by this cycle's pop, so a full queue still accepts one.
    assign w_space      = CNT_W'(UQ_DEPTH) - w_count + {{(CNT_W-1){1'b0}}, w_deq};
    assign commit_stall = (w_count > CNT_W'(UQ_DEPTH - COMMIT_WIDTH));
    assign uq_count     = w_count;
    assign uq_overflow  = r_overflow;

    always_comb begin
        w_qual  = '0;
        w_entry = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            w_qual[i]                      = commit_valid[i] & (commit_is_jal[i] | commit_is_branch[i]);
            w_entry[i].pc                  = commit_pc[i];
            w_entry[i].pred_branch_address = commit_target[i];
            w_entry[i].jal_inst            = commit_is_jal[i];
            w_entry[i].branch_inst         = commit_is_branch[i] & ~commit_is_jal[i];
            w_entry[i].branch_resol        = commit_is_jal[i] | commit_taken[i];
        end
    end

    btb_uq_compactor #(
        .COMMIT_WIDTH (COMMIT_WIDTH),
        .CNT_W        (CNT_W)
    ) u_compactor (
        .i_qual   (w_qual),
        .i_space  (w_space),
        .o_offset (w_offset),
        .o_accept (w_accept),
        .o_n_enq  (w_n_enq),
        .o_n_drop (w_n_drop)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_tail <= r_tail + w_n_enq;
            if (w_deq) begin
                r_head <= r_head + 1'b1;
            end
            if (w_n_drop != '0) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (w_accept[i]) begin
                r_mem[r_tail[IDX_W-1:0] + w_offset[i]] <= w_entry[i];
            end
        end
    end

    assign w_head_entry = r_mem[r_head[IDX_W-1:0]];

    always_comb begin
        btb_upd = '0;
        if (w_deq) begin
            btb_upd.pc                  = w_head_entry.pc;
            btb_upd.pred_branch_address = w_head_entry.pred_branch_address;
            btb_upd.jal_inst            = w_head_entry.jal_inst;
            btb_upd.branch_inst         = w_head_entry.branch_inst;
            btb_upd.branch_resol        = w_head_entry.branch_resol;
            btb_upd.ready               = 1'b1;
            btb_upd.valid               = 1'b1;
        end
    end

`ifdef BTB_UQ_STATS_EN
    logic [31:0] r_stat_enq;
    logic [31:0] r_stat_taken;
    logic [31:0] r_stat_jal;
    logic [31:0] r_stat_drop;
    logic [31:0] r_stat_stall;
    logic [31:0] w_n_taken;
    logic [31:0] w_n_jal;

    always_comb begin
        w_n_taken = '0;
        w_n_jal   = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (w_accept[i] && w_entry[i].jal_inst) begin
                w_n_jal = w_n_jal + 32'd1;
            end
            if (w_accept[i] && w_entry[i].branch_inst && w_entry[i].branch_resol) begin
                w_n_taken = w_n_taken + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_enq   <= '0;
            r_stat_taken <= '0;
            r_stat_jal   <= '0;
            r_stat_drop  <= '0;
            r_stat_stall <= '0;
        end else begin
            r_stat_enq   <= uq_sat_add(r_stat_enq, 32'(w_n_enq));
            r_stat_taken <= uq_sat_add(r_stat_taken, w_n_taken);
            r_stat_jal   <= uq_sat_add(r_stat_jal, w_n_jal);
            r_stat_drop  <= uq_sat_add(r_stat_drop, 32'(w_n_drop));
            r_stat_stall <= uq_sat_add(r_stat_stall, {31'd0, commit_stall});
        end
    end

    assign stat_enq          = r_stat_enq;
    assign stat_taken        = r_stat_taken;
    assign stat_jal          = r_stat_jal;
    assign stat_drop         = r_stat_drop;
    assign stat_stall_cycles = r_stat_stall;
`endif

endmodule

// File: tb/tb_btb_commit_update_queue.sv
// Scoreboard bench for btb_commit_update_queue; stat checks only when BTB_UQ_STATS_EN is defined.
module tb_btb_commit_update_queue;
    import rv32i_types::*;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       commit_valid;
    logic [1:0][31:0] commit_pc;
    logic [1:0][31:0] commit_target;
    logic [1:0]       commit_is_jal;
    logic [1:0]       commit_is_branch;
    logic [1:0]       commit_taken;
    logic             commit_stall;
    rob_to_btb_bus    btb_upd;
    logic [3:0]       uq_count;
    logic             uq_overflow;
`ifdef BTB_UQ_STATS_EN
    logic [31:0]      stat_enq;
    logic [31:0]      stat_taken;
    logic [31:0]      stat_jal;
    logic [31:0]      stat_drop;
    logic [31:0]      stat_stall_cycles;
`endif

    rob_to_btb_bus exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    localparam int T3_CNT [7] = '{0, 2, 3, 4, 5, 6, 7};

    btb_commit_update_queue #(
        .UQ_DEPTH      (8),
        .UQ_DEPTH_BITS (3),
        .COMMIT_WIDTH  (2)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .commit_valid     (commit_valid),
        .commit_pc        (commit_pc),
        .commit_target    (commit_target),
        .commit_is_jal    (commit_is_jal),
        .commit_is_branch (commit_is_branch),
        .commit_taken     (commit_taken),
        .commit_stall     (commit_stall),
        .btb_upd          (btb_upd),
        .uq_count         (uq_count),
        .uq_overflow      (uq_overflow)
`ifdef BTB_UQ_STATS_EN
        ,
        .stat_enq          (stat_enq),
        .stat_taken        (stat_taken),
        .stat_jal          (stat_jal),
        .stat_drop         (stat_drop),
        .stat_stall_cycles (stat_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    task automatic idle();
        commit_valid     = '0;
        commit_pc        = '0;
        commit_target    = '0;
        commit_is_jal    = '0;
        commit_is_branch = '0;
        commit_taken     = '0;
    endtask

    task automatic slot(input int s, input logic [31:0] pc, input logic [31:0] tgt,
                        input logic j, input logic b, input logic t);
        commit_valid[s]     = 1'b1;
        commit_pc[s]        = pc;
        commit_target[s]    = tgt;
        commit_is_jal[s]    = j;
        commit_is_branch[s] = b;
        commit_taken[s]     = t;
    endtask

    task automatic exp_push(input logic [31:0] pc, input logic [31:0] tgt, input logic j,
                            input logic b, input logic resol);
        rob_to_btb_bus e;
        e                     = '0;
        e.pc                  = pc;
        e.pred_branch_address = tgt;
        e.jal_inst            = j;
        e.branch_inst         = b;
        e.branch_resol        = resol;
        e.ready               = 1'b1;
        e.valid               = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while ((uq_count != 4'd0 || exp_q.size() != 0) && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_drain_count"}, 128'(uq_count), 128'(0));
        chk({name, "_drain_pending"}, 128'(exp_q.size()), 128'(0));
        @(negedge clk);
    endtask

    // Monitor: every non-reset cycle either pops and matches an update or checks the idle bus.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (btb_upd.valid) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_upd: got pc %h, want no update", btb_upd.pc);
                    end else begin
                        chk("btb_upd", 128'(btb_upd), 128'(exp_q.pop_front()));
                    end
                end else begin
                    chk("idle_upd", 128'(btb_upd), 128'(0));
                end
            end
        end
    end

    initial begin
        idle();
        #12 rst = 1'b0;
        @(negedge clk);
        chk("rst_count", 128'(uq_count), 128'(0));
        chk("rst_stall", 128'(commit_stall), 128'(0));
        chk("rst_ovf", 128'(uq_overflow), 128'(0));

        // Single taken branch into an empty queue.
        slot(0, 32'h1000, 32'h1040, 1'b0, 1'b1, 1'b1);
        exp_push(32'h1000, 32'h1040, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        idle();
        chk("t1_count", 128'(uq_count), 128'(1));
        chk("t1_valid", 128'(btb_upd.valid), 128'(1));
        @(negedge clk);
        chk("t1_count_after", 128'(uq_count), 128'(0));
        wait_drain("t1");

        // ALU op in slot0 (ignored) plus jal in slot1; jal resolves taken regardless of input.
        commit_valid[0] = 1'b1;
        commit_pc[0]    = 32'h2000;
        slot(1, 32'h2004, 32'h2100, 1'b1, 1'b0, 1'b0);
        exp_push(32'h2004, 32'h2100, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        idle();
        chk("t2_count", 128'(uq_count), 128'(1));
        wait_drain("t2");

        // Both jal and branch set: jal wins; invalid slot1 with is_branch is ignored.
        slot(0, 32'h2800, 32'h2900, 1'b1, 1'b1, 1'b0);
        commit_is_branch[1] = 1'b1;
        exp_push(32'h2800, 32'h2900, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        idle();
        chk("t2b_count", 128'(uq_count), 128'(1));
        wait_drain("t2b");

        // Two branches per cycle for six cycles: stall rises only once count reaches 7.
        for (int c = 0; c < 6; c++) begin
            chk("t3_count", 128'(uq_count), 128'(T3_CNT[c]));
            chk("t3_stall", 128'(commit_stall), 128'(T3_CNT[c] > 6));
            for (int s = 0; s < 2; s++) begin
                slot(s, 32'h4000 + 32'(8 * c + 4 * s), 32'h5000 + 32'(8 * c + 4 * s),
                     1'b0, 1'b1, 1'(c + s));
                exp_push(32'h4000 + 32'(8 * c + 4 * s), 32'h5000 + 32'(8 * c + 4 * s),
                         1'b0, 1'b1, 1'(c + s));
            end
            @(negedge clk);
        end
        idle();
        chk("t3_count7", 128'(uq_count), 128'(7));
        chk("t3_stall7", 128'(commit_stall), 128'(1));
        wait_drain("t3");
        chk("t3_ovf", 128'(uq_overflow), 128'(0));

        // Fill to full, then push two with the queue full: slot0 takes the popped entry.
        for (int c = 0; c < 7; c++) begin
            for (int s = 0; s < 2; s++) begin
                slot(s, 32'h6000 + 32'(8 * c + 4 * s), 32'h6800 + 32'(8 * c + 4 * s),
                     1'b0, 1'b1, 1'b0);
                exp_push(32'h6000 + 32'(8 * c + 4 * s), 32'h6800 + 32'(8 * c + 4 * s),
                         1'b0, 1'b1, 1'b0);
            end
            @(negedge clk);
        end
        chk("t4_full_count", 128'(uq_count), 128'(8));
        chk("t4_full_stall", 128'(commit_stall), 128'(1));
        chk("t4_ovf_before", 128'(uq_overflow), 128'(0));
        slot(0, 32'h6F00, 32'h6F40, 1'b0, 1'b1, 1'b1);
        slot(1, 32'h6F04, 32'h6F44, 1'b0, 1'b1, 1'b1);
        exp_push(32'h6F00, 32'h6F40, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        idle();
        chk("t4_count_after", 128'(uq_count), 128'(8));
        chk("t4_ovf_set", 128'(uq_overflow), 128'(1));
        wait_drain("t4");
        chk("t4_ovf_held", 128'(uq_overflow), 128'(1));

        // Asynchronous reset mid-drain at count 5.
        for (int c = 0; c < 4; c++) begin
            for (int s = 0; s < 2; s++) begin
                slot(s, 32'h8000 + 32'(8 * c + 4 * s), 32'h8800, 1'b0, 1'b1, 1'b0);
                exp_push(32'h8000 + 32'(8 * c + 4 * s), 32'h8800, 1'b0, 1'b1, 1'b0);
            end
            @(negedge clk);
        end
        idle();
        chk("t5_count5", 128'(uq_count), 128'(5));
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_upd", 128'(btb_upd), 128'(0));
        chk("t5_rst_count", 128'(uq_count), 128'(0));
        chk("t5_rst_stall", 128'(commit_stall), 128'(0));
        chk("t5_rst_ovf", 128'(uq_overflow), 128'(0));
        exp_q.delete();
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("t5_post_count", 128'(uq_count), 128'(0));
        slot(0, 32'h9000, 32'h9100, 1'b0, 1'b1, 1'b1);
        exp_push(32'h9000, 32'h9100, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        idle();
        chk("t5_new_count", 128'(uq_count), 128'(1));
        wait_drain("t5");

`ifdef BTB_UQ_STATS_EN
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        slot(0, 32'hA000, 32'hA100, 1'b0, 1'b1, 1'b1);
        slot(1, 32'hA004, 32'hA104, 1'b0, 1'b1, 1'b1);
        exp_push(32'hA000, 32'hA100, 1'b0, 1'b1, 1'b1);
        exp_push(32'hA004, 32'hA104, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        slot(0, 32'hA008, 32'hA108, 1'b0, 1'b1, 1'b1);
        slot(1, 32'hA00C, 32'hA10C, 1'b0, 1'b1, 1'b0);
        exp_push(32'hA008, 32'hA108, 1'b0, 1'b1, 1'b1);
        exp_push(32'hA00C, 32'hA10C, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        slot(0, 32'hA010, 32'hA200, 1'b1, 1'b0, 1'b1);
        slot(1, 32'hA014, 32'hA300, 1'b1, 1'b0, 1'b1);
        exp_push(32'hA010, 32'hA200, 1'b1, 1'b0, 1'b1);
        exp_push(32'hA014, 32'hA300, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        idle();
        wait_drain("stats");
        chk("stat_enq", 128'(stat_enq), 128'(6));
        chk("stat_taken", 128'(stat_taken), 128'(3));
        chk("stat_jal", 128'(stat_jal), 128'(2));
        chk("stat_drop", 128'(stat_drop), 128'(0));
        chk("stat_stall_cycles", 128'(stat_stall_cycles), 128'(0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
